bus_width_increase: RTL and testbench



---
 rtl/fifo_pkg.sv | 14 +
 rtl/bus_width_increase.sv | 123 ++++++++++++
 tb/tb_bus_width_increase.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Helpers shared by the width-increase and width-decrease stages of the stream path.
package fifo_pkg;

    function automatic int unsigned ratio(input int unsigned size_out, input int unsigned size_in);
        return size_out / size_in;
    endfunction

    // Lane that beat k of a word occupies.
    function automatic int unsigned lane_of(input int unsigned k, input int unsigned r,
                                            input bit little_endian);
        return little_endian ? k : (r - 1 - k);
    endfunction

endpackage

// File: rtl/bus_width_increase.sv
// Packs RATIO narrow beats into one wide word; input_last flushes a partial word with a keep mask.
// The output word is registered, and a second word can wait in the accumulator while it stalls.
module bus_width_increase
    import fifo_pkg::*;
#(
    parameter int unsigned SIZE_IN       = 8,
    parameter int unsigned SIZE_OUT      = 32,
    parameter bit          LITTLE_ENDIAN = 1'b1,
    localparam int unsigned RATIO        = ratio(SIZE_OUT, SIZE_IN)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                input_ready,
    input  logic                input_valid,
    input  logic [SIZE_IN-1:0]  data_in,
    input  logic                input_last,
    input  logic                output_ready,
    output logic                output_valid,
    output logic [SIZE_OUT-1:0] data_out,
    output logic [RATIO-1:0]    output_keep,
    output logic                output_last
);

    localparam int unsigned PTR_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    if ((SIZE_OUT % SIZE_IN) != 0 || RATIO < 2) begin : g_bad_params
        $error("bus_width_increase: SIZE_OUT must be a multiple of SIZE_IN with ratio >= 2");
    end

    logic [SIZE_OUT-1:0] r_acc;
    logic [RATIO-1:0]    r_acc_keep;
    logic                r_acc_last;
    logic [PTR_W-1:0]    r_ptr;
    logic                r_acc_full;
    logic                r_out_valid;
    logic [SIZE_OUT-1:0] r_data_out;
    logic [RATIO-1:0]    r_out_keep;
    logic                r_out_last;

    logic                w_in_fire;
    logic                w_out_free;
    logic                w_complete;
    int unsigned         w_lane;
    logic [SIZE_OUT-1:0] w_merged;
    logic [RATIO-1:0]    w_merged_keep;

    assign input_ready  = ~r_acc_full;
    assign output_valid = r_out_valid;
    assign data_out     = r_data_out;
    assign output_keep  = r_out_keep;
    assign output_last  = r_out_last;

    assign w_in_fire  = input_valid & ~r_acc_full;
    assign w_out_free = ~r_out_valid | output_ready;
    assign w_complete = w_in_fire & ((r_ptr == PTR_W'(RATIO - 1)) | input_last);

    // Accumulator with the incoming beat written into its lane.
    always_comb begin
        w_lane        = lane_of(int'(r_ptr), RATIO, LITTLE_ENDIAN);
        w_merged      = r_acc;
        w_merged_keep = r_acc_keep;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (i == w_lane) begin
                w_merged[i*SIZE_IN +: SIZE_IN] = data_in;
                w_merged_keep[i]               = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_acc_keep  <= '0;
            r_acc_last  <= 1'b0;
            r_ptr       <= '0;
            r_acc_full  <= 1'b0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_out_valid && output_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_acc_full) begin
                if (w_out_free) begin
                    r_out_valid <= 1'b1;
                    r_data_out  <= r_acc;
                    r_out_keep  <= r_acc_keep;
                    r_out_last  <= r_acc_last;
                    r_acc_full  <= 1'b0;
                    r_acc       <= '0;
                    r_acc_keep  <= '0;
                    r_acc_last  <= 1'b0;
                    r_ptr       <= '0;
                end
            end else if (w_in_fire) begin
                if (w_complete && w_out_free) begin
                    r_out_valid <= 1'b1;
                    r_data_out  <= w_merged;
                    r_out_keep  <= w_merged_keep;
                    r_out_last  <= input_last;
                    r_acc       <= '0;
                    r_acc_keep  <= '0;
                    r_acc_last  <= 1'b0;
                    r_ptr       <= '0;
                end else if (w_complete) begin
                    // Output still held: park the finished word and stall the input.
                    r_acc      <= w_merged;
                    r_acc_keep <= w_merged_keep;
                    r_acc_last <= input_last;
                    r_acc_full <= 1'b1;
                    r_ptr      <= '0;
                end else begin
                    r_acc      <= w_merged;
                    r_acc_keep <= w_merged_keep;
                    r_ptr      <= r_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_width_increase.sv
// Scoreboard bench: drives one beat stream into little- and big-endian instances side by side.
module tb_bus_width_increase;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  data_in = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        rdy_le, val_le, last_le, rdy_be, val_be, last_be;
    logic [31:0] dout_le, dout_be;
    logic [3:0]  keep_le, keep_be;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [36:0] q_le[$];
    logic [36:0] q_be[$];
    logic        hold[2] = '{1'b0, 1'b0};
    logic [36:0] saved[2];

    bus_width_increase #(.SIZE_IN(8), .SIZE_OUT(32), .LITTLE_ENDIAN(1'b1)) u_le (
        .clk(clk), .rst_n(rst_n), .input_ready(rdy_le), .input_valid(in_valid),
        .data_in(data_in), .input_last(in_last), .output_ready(out_ready),
        .output_valid(val_le), .data_out(dout_le), .output_keep(keep_le), .output_last(last_le)
    );

    bus_width_increase #(.SIZE_IN(8), .SIZE_OUT(32), .LITTLE_ENDIAN(1'b0)) u_be (
        .clk(clk), .rst_n(rst_n), .input_ready(rdy_be), .input_valid(in_valid),
        .data_in(data_in), .input_last(in_last), .output_ready(out_ready),
        .output_valid(val_be), .data_out(dout_be), .output_keep(keep_be), .output_last(last_be)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d_le, input logic [3:0] k_le,
                        input logic [31:0] d_be, input logic [3:0] k_be, input logic l);
        q_le.push_back({l, k_le, d_le});
        q_be.push_back({l, k_be, d_be});
    endtask

    task automatic mon(input int idx, input logic v, input logic [36:0] w);
        logic [36:0] exp;
        if (hold[idx]) check($sformatf("stable%0d", idx), {v, w}, {1'b1, saved[idx]});
        hold[idx]  = v & ~out_ready;
        saved[idx] = w;
        if (v && out_ready) begin
            if (idx == 0 && q_le.size() == 0 || idx == 1 && q_be.size() == 0) begin
                check($sformatf("unexpected%0d", idx), w, '0);
                if (w == '0) begin
                    bad++;
                    $display("FAIL unexpected%0d: got word %h want none", idx, w);
                end
            end else begin
                exp = (idx == 0) ? q_le.pop_front() : q_be.pop_front();
                check($sformatf("word%0d", idx), w, exp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            hold[0] = 1'b0;
            hold[1] = 1'b0;
        end else begin
            mon(0, val_le, {last_le, keep_le, dout_le});
            mon(1, val_be, {last_be, keep_be, dout_be});
        end
    end

    task automatic drive(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        data_in  = d;
        in_last  = l;
        forever begin
            @(negedge clk);
            if (rdy_le && rdy_be) break;
            n++;
            if (n >= 40) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got ready=0 want ready=1 within 40 cycles");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 30 && (q_le.size() != 0 || q_be.size() != 0); n++) @(posedge clk);
        #1;
        check("drain_le", 37'(q_le.size()), 37'd0);
        check("drain_be", 37'(q_be.size()), 37'd0);
    endtask

    logic [7:0] rb[64];
    int c0;

    initial begin
        #1;
        check("rst_ready", {36'd0, rdy_le}, 37'd1);
        check("rst_out", {val_le, last_le, keep_le, dout_le}, 38'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full word, both lane orders; valid one cycle after the fourth beat.
        push(32'h44332211, 4'hF, 32'h11223344, 4'hF, 1'b0);
        drive(8'h11, 1'b0);
        drive(8'h22, 1'b0);
        drive(8'h33, 1'b0);
        check("pre_valid", {35'd0, val_le, val_be}, 37'd0);
        drive(8'h44, 1'b0);
        check("latency", {35'd0, val_le, val_be}, 37'd3);

        // Partial flush then a fresh word starting at beat 0.
        push(32'h0000BBAA, 4'b0011, 32'hAABB0000, 4'b1100, 1'b1);
        push(32'h04030201, 4'hF, 32'h01020304, 4'hF, 1'b0);
        drive(8'hAA, 1'b0);
        drive(8'hBB, 1'b1);
        for (int i = 1; i <= 4; i++) drive(8'(i), 1'b0);
        wait_drain();

        // Back-pressure: two words pile up, input stalls, then drains in order.
        out_ready = 1'b0;
        push(32'h04030201, 4'hF, 32'h01020304, 4'hF, 1'b0);
        push(32'h08070605, 4'hF, 32'h05060708, 4'hF, 1'b0);
        push(32'h0C0B0A09, 4'hF, 32'h090A0B0C, 4'hF, 1'b0);
        for (int i = 1; i <= 8; i++) drive(8'(i), 1'b0);
        check("stall_ready", {35'd0, rdy_le, rdy_be}, 37'd0);
        in_valid = 1'b1;
        data_in  = 8'h09;
        repeat (3) @(posedge clk);
        #1;
        check("stall_hold", {5'd0, dout_le}, {5'd0, 32'h04030201});
        check("stall_ready2", {35'd0, rdy_le, rdy_be}, 37'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_ready", {35'd0, rdy_le, rdy_be}, 37'd3);
        check("drain_word", {4'd0, val_le, dout_le}, {4'd0, 1'b1, 32'h08070605});
        for (int i = 9; i <= 12; i++) drive(8'(i), 1'b0);
        wait_drain();

        // Continuous random stream; one beat accepted every cycle.
        for (int i = 0; i < 64; i++) rb[i] = 8'($urandom_range(0, 255));
        for (int w = 0; w < 16; w++)
            push({rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]}, 4'hF,
                 {rb[4*w], rb[4*w+1], rb[4*w+2], rb[4*w+3]}, 4'hF, 1'b0);
        c0 = cyc;
        for (int i = 0; i < 64; i++) drive(rb[i], 1'b0);
        check("no_bubbles", 37'(cyc - c0), 37'd64);
        wait_drain();

        // Reset with a held output word and a partial word in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) drive(8'hD0 + 8'(i), 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_le", {rdy_le, val_le, last_le, keep_le, dout_le}, {1'b1, 38'd0});
        check("mid_rst_be", {rdy_be, val_be, last_be, keep_be, dout_be}, {1'b1, 38'd0});
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        push(32'h88776655, 4'hF, 32'h55667788, 4'hF, 1'b0);
        drive(8'h55, 1'b0);
        drive(8'h66, 1'b0);
        drive(8'h77, 1'b0);
        drive(8'h88, 1'b0);
        wait_drain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
